// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types and defaults for the I2C byte-command bus arbiter.
package i2c_bus_arbiter_pkg;

    localparam int unsigned IDLE_TIMEOUT_DEFAULT = 1_000_000;
    // Width of the latched write byte; the arbiter's DATA_WIDTH must not exceed it.
    localparam int unsigned CMD_DIN_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StBusy,
        StCmd,
        StForceStop,
        StRelease
    } arb_state_t;

    typedef struct packed {
        logic                 start;
        logic                 stop;
        logic                 read;
        logic                 write;
        logic                 ack_in;
        logic [CMD_DIN_W-1:0] din;
    } i2c_cmd_t;

    localparam i2c_cmd_t FORCE_STOP_CMD = '{
        start: 1'b0, stop: 1'b1, read: 1'b0, write: 1'b0, ack_in: 1'b1, din: '0
    };

endpackage

// File: rtl/i2c_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot pick of the first requester after last_i.
module i2c_bus_arbiter_rr_picker #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_i,
    output logic [NUM_REQ-1:0]         pick_o
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [IdxW-1:0] idx;

    // Walk from the farthest candidate back to the nearest so the nearest one wins.
    always_comb begin
        pick_o = '0;
        idx    = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            idx = IdxW'((32'(last_i) + k) % NUM_REQ);
            if (req_i[idx]) begin
                pick_o      = '0;
                pick_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C byte-controller command port among NUM_REQ requesters, holding the
// grant for a whole START..STOP transaction and recovering the bus with a forced STOP.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            start_i,
    input  logic [NUM_REQ-1:0]            stop_i,
    input  logic [NUM_REQ-1:0]            read_i,
    input  logic [NUM_REQ-1:0]            write_i,
    input  logic [NUM_REQ-1:0]            ack_in_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [NUM_REQ-1:0]            cmd_ack_o,
    output logic [NUM_REQ-1:0]            err_o,
    output logic [DATA_WIDTH-1:0]         dout_o,
    output logic                          ack_out_o,
    output logic                          m_start_o,
    output logic                          m_stop_o,
    output logic                          m_read_o,
    output logic                          m_write_o,
    output logic                          m_ack_in_o,
    output logic [DATA_WIDTH-1:0]         m_din_o,
    input  logic                          m_cmd_ack_i,
    input  logic                          m_ack_out_i,
    input  logic                          m_al_i,
    input  logic [DATA_WIDTH-1:0]         m_dout_i
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(IDLE_TIMEOUT + 1);

    arb_state_t          state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  err_q;
    logic [IdxW-1:0]     last_q;
    logic [CntW-1:0]     idle_cnt_q;
    logic                in_txn_q;
    logic                guard_q;
    i2c_cmd_t            cmd_q;

    logic [NUM_REQ-1:0]  pick;
    logic [IdxW-1:0]     g_idx;
    i2c_cmd_t            sel_cmd;
    logic                req_g;
    logic                cmd_valid;
    logic                cmd_illegal;
    logic                idle_hit;

    i2c_bus_arbiter_rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req_i (req_i),
        .last_i(last_q),
        .pick_o(pick)
    );

    always_comb begin
        g_idx   = '0;
        sel_cmd = '0;
        req_g   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx          = IdxW'(i);
                req_g          = req_i[i];
                sel_cmd.start  = start_i[i];
                sel_cmd.stop   = stop_i[i];
                sel_cmd.read   = read_i[i];
                sel_cmd.write  = write_i[i];
                sel_cmd.ack_in = ack_in_i[i];
                sel_cmd.din    = CMD_DIN_W'(din_i[i*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    // The guard cycle after an ack stops a requester's stale command from replaying.
    assign cmd_valid   = !guard_q && |{sel_cmd.start, sel_cmd.stop, sel_cmd.read,
                                       sel_cmd.write, sel_cmd.ack_in};
    assign cmd_illegal = sel_cmd.read && sel_cmd.write;
    assign idle_hit    = idle_cnt_q >= CntW'(IDLE_TIMEOUT - 1);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            err_q      <= '0;
            last_q     <= IdxW'(NUM_REQ - 1);
            idle_cnt_q <= '0;
            in_txn_q   <= 1'b0;
            guard_q    <= 1'b0;
            cmd_q      <= '0;
        end else begin
            err_q   <= '0;
            guard_q <= 1'b0;
            // Lost arbitration: another master owns the bus, so just let go, no STOP.
            if (m_al_i && state_q inside {StBusy, StCmd, StForceStop}) begin
                err_q    <= grant_q;
                cmd_q    <= '0;
                in_txn_q <= 1'b0;
                state_q  <= StRelease;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (|req_i) begin
                            grant_q    <= pick;
                            idle_cnt_q <= '0;
                            state_q    <= StBusy;
                        end
                    end
                    StBusy: begin
                        if (cmd_valid && cmd_illegal) begin
                            err_q <= grant_q;
                        end else if (cmd_valid) begin
                            cmd_q   <= sel_cmd;
                            state_q <= StCmd;
                        end else if (!req_g) begin
                            if (in_txn_q) begin
                                err_q   <= grant_q;
                                cmd_q   <= FORCE_STOP_CMD;
                                state_q <= StForceStop;
                            end else begin
                                state_q <= StRelease;
                            end
                        end else if (idle_hit) begin
                            err_q      <= grant_q;
                            idle_cnt_q <= CntW'(IDLE_TIMEOUT);
                            if (in_txn_q) begin
                                cmd_q   <= FORCE_STOP_CMD;
                                state_q <= StForceStop;
                            end else begin
                                state_q <= StRelease;
                            end
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end
                    StCmd: begin
                        if (m_cmd_ack_i) begin
                            if (cmd_q.start) in_txn_q <= 1'b1;
                            if (cmd_q.stop)  in_txn_q <= 1'b0;
                            cmd_q      <= '0;
                            idle_cnt_q <= '0;
                            guard_q    <= 1'b1;
                            state_q    <= StBusy;
                        end
                    end
                    StForceStop: begin
                        if (m_cmd_ack_i) begin
                            cmd_q    <= '0;
                            in_txn_q <= 1'b0;
                            state_q  <= StRelease;
                        end
                    end
                    StRelease: begin
                        grant_q <= '0;
                        last_q  <= g_idx;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign cmd_ack_o  = (state_q == StCmd && m_cmd_ack_i && !m_al_i) ? grant_q : '0;
    assign grant_o    = grant_q;
    assign err_o      = err_q;
    assign m_start_o  = cmd_q.start;
    assign m_stop_o   = cmd_q.stop;
    assign m_read_o   = cmd_q.read;
    assign m_write_o  = cmd_q.write;
    assign m_ack_in_o = cmd_q.ack_in;
    assign m_din_o    = cmd_q.din[DATA_WIDTH-1:0];
    assign dout_o     = m_dout_i;
    assign ack_out_o  = m_ack_out_i;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Table-driven bench for i2c_bus_arbiter: per-cycle stimulus rows with a queue of expectations.
module tb_i2c_bus_arbiter;

    localparam logic [4:0] C_NONE = 5'b00000;  // {start, stop, read, write, ack_in}
    localparam logic [4:0] C_SW   = 5'b10010;
    localparam logic [4:0] C_STOP = 5'b01000;
    localparam logic [4:0] C_RW   = 5'b00110;
    localparam logic [4:0] C_SRA  = 5'b10101;
    localparam logic [4:0] C_FS   = 5'b01001;

    typedef struct {
        string      name;
        int         reps;
        logic       rst_n;
        logic [1:0] req;
        logic [4:0] c0, c1;
        logic [7:0] d0, d1;
        logic       mack, mal;
        logic [1:0] e_grant, e_cack, e_err;
        logic [4:0] e_m;
        logic [7:0] e_din;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] grant, cack, err;
        logic [4:0] m;
        logic [7:0] din, dout;
        logic       ack_out;
    } exp_t;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [1:0]  req = '0, start = '0, stop = '0, read = '0, write = '0, ack_in = '0;
    logic [15:0] din = '0;
    logic [1:0]  grant, cmd_ack, err;
    logic [7:0]  dout, m_din, m_dout = '0;
    logic        ack_out, m_start, m_stop, m_read, m_write, m_ack_in;
    logic        m_cmd_ack = 1'b0, m_ack_out = 1'b0, m_al = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    i2c_bus_arbiter #(
        .NUM_REQ     (2),
        .DATA_WIDTH  (8),
        .IDLE_TIMEOUT(16)
    ) dut (
        .clk_i      (clk),
        .arstn_i    (arstn),
        .req_i      (req),
        .start_i    (start),
        .stop_i     (stop),
        .read_i     (read),
        .write_i    (write),
        .ack_in_i   (ack_in),
        .din_i      (din),
        .grant_o    (grant),
        .cmd_ack_o  (cmd_ack),
        .err_o      (err),
        .dout_o     (dout),
        .ack_out_o  (ack_out),
        .m_start_o  (m_start),
        .m_stop_o   (m_stop),
        .m_read_o   (m_read),
        .m_write_o  (m_write),
        .m_ack_in_o (m_ack_in),
        .m_din_o    (m_din),
        .m_cmd_ack_i(m_cmd_ack),
        .m_ack_out_i(m_ack_out),
        .m_al_i     (m_al),
        .m_dout_i   (m_dout)
    );

    function automatic vec_t v(string n, int r, logic rn, logic [1:0] rq, logic [4:0] c0,
                               logic [4:0] c1, logic [7:0] d0, logic [7:0] d1, logic mack,
                               logic mal, logic [1:0] eg, logic [1:0] eca, logic [1:0] ee,
                               logic [4:0] em, logic [7:0] ed);
        vec_t t;
        t.name = n; t.reps = r; t.rst_n = rn; t.req = rq; t.c0 = c0; t.c1 = c1;
        t.d0 = d0; t.d1 = d1; t.mack = mack; t.mal = mal;
        t.e_grant = eg; t.e_cack = eca; t.e_err = ee; t.e_m = em; t.e_din = ed;
        return t;
    endfunction

    task automatic check_one();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got an output sample, want a queued expectation");
            return;
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({grant, cmd_ack, err, m_start, m_stop, m_read, m_write, m_ack_in, m_din, dout,
             ack_out} !== {e.grant, e.cack, e.err, e.m, e.din, e.dout, e.ack_out}) begin
            n_fail++;
            $display("FAIL %s: got grant=%b cmd_ack=%b err=%b m=%b m_din=%h dout=%h ack_out=%b, want grant=%b cmd_ack=%b err=%b m=%b m_din=%h dout=%h ack_out=%b",
                     e.name, grant, cmd_ack, err,
                     {m_start, m_stop, m_read, m_write, m_ack_in}, m_din, dout, ack_out,
                     e.grant, e.cack, e.err, e.m, e.din, e.dout, e.ack_out);
        end
    endtask

    task automatic apply(input vec_t t);
        exp_t e;
        for (int r = 0; r < t.reps; r++) begin
            @(negedge clk);
            arstn     = t.rst_n;
            req       = t.req;
            start     = {t.c1[4], t.c0[4]};
            stop      = {t.c1[3], t.c0[3]};
            read      = {t.c1[2], t.c0[2]};
            write     = {t.c1[1], t.c0[1]};
            ack_in    = {t.c1[0], t.c0[0]};
            din       = {t.d1, t.d0};
            m_cmd_ack = t.mack;
            m_al      = t.mal;
            m_dout    = 8'($urandom);
            m_ack_out = 1'($urandom);
            e.name = t.name; e.grant = t.e_grant; e.cack = t.e_cack; e.err = t.e_err;
            e.m = t.e_m; e.din = t.e_din; e.dout = m_dout; e.ack_out = m_ack_out;
            exp_q.push_back(e);
            #1;
            check_one();
        end
    endtask

    initial begin
        // Single write with a late ack, then a STOP and a clean release.
        tbl.push_back(v("reset",    2, 0, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("sw_req",   1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("sw_cmd",   1, 1, 2'b01, C_SW,   C_NONE, 8'hEA, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("sw_wait", 19, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_SW,   8'hEA));
        tbl.push_back(v("sw_ack",   1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 1, 0, 2'b01, 2'b01, 2'b00, C_SW,   8'hEA));
        tbl.push_back(v("sw_gap",   1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("sw_stop",  1, 1, 2'b01, C_STOP, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("sw_sack",  1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 1, 0, 2'b01, 2'b01, 2'b00, C_STOP, 8'h00));
        tbl.push_back(v("sw_drop",  1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("sw_rel",   1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("sw_idle",  1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        // Contention out of reset: requester 0 first, then 1, then 0 again.
        tbl.push_back(v("ct_rst",   1, 0, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ct_req",   1, 1, 2'b11, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ct_g0",    2, 1, 2'b11, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ct_drop0", 1, 1, 2'b10, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ct_rel0",  1, 1, 2'b10, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ct_gap",   1, 1, 2'b11, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ct_g1",    3, 1, 2'b11, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b10, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ct_drop1", 1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b10, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ct_rel1",  1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b10, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ct_gap2",  1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ct_g0b",   1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ct_drop",  1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ct_rel",   1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ct_end",   1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        // Abandoned transaction: forced STOP held until ack, err on entry.
        tbl.push_back(v("ab_req",   1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ab_cmd",   1, 1, 2'b01, C_SW,   C_NONE, 8'h5A, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ab_wait",  2, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_SW,   8'h5A));
        tbl.push_back(v("ab_ack",   1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 1, 0, 2'b01, 2'b01, 2'b00, C_SW,   8'h5A));
        tbl.push_back(v("ab_drop",  1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ab_fs",    1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b01, C_FS,   8'h00));
        tbl.push_back(v("ab_fsw",   2, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_FS,   8'h00));
        tbl.push_back(v("ab_fsack", 1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 1, 0, 2'b01, 2'b00, 2'b00, C_FS,   8'h00));
        tbl.push_back(v("ab_rel",   1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("ab_end",   1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        // Idle timeout with no open transaction: err at grant+16, then release.
        tbl.push_back(v("to_req",   1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("to_wait", 16, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("to_err",   1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b01, C_NONE, 8'h00));
        tbl.push_back(v("to_end",   1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        // Idle timeout inside a transaction: single err pulse plus a forced STOP.
        tbl.push_back(v("tt_req",   1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("tt_cmd",   1, 1, 2'b01, C_SW,   C_NONE, 8'h11, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("tt_ack",   1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 1, 0, 2'b01, 2'b01, 2'b00, C_SW,   8'h11));
        tbl.push_back(v("tt_wait", 16, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("tt_err",   1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b01, C_FS,   8'h00));
        tbl.push_back(v("tt_fsack", 1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 1, 0, 2'b01, 2'b00, 2'b00, C_FS,   8'h00));
        tbl.push_back(v("tt_rel",   1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("tt_end",   1, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        // Arbitration lost together with ack: no cmd_ack, err, other requester next.
        tbl.push_back(v("al_req",   1, 1, 2'b11, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("al_cmd",   1, 1, 2'b11, C_RW,   C_SW,   8'hFF, 8'h3C, 0, 0, 2'b10, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("al_wait",  1, 1, 2'b11, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b10, 2'b00, 2'b00, C_SW,   8'h3C));
        tbl.push_back(v("al_hit",   1, 1, 2'b11, C_NONE, C_NONE, 8'h00, 8'h00, 1, 1, 2'b10, 2'b00, 2'b00, C_SW,   8'h3C));
        tbl.push_back(v("al_rel",   1, 1, 2'b11, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b10, 2'b00, 2'b10, C_NONE, 8'h00));
        tbl.push_back(v("al_gap",   1, 1, 2'b11, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("al_g0",    1, 1, 2'b11, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        // Illegal read+write, then a legal command cut short by asynchronous reset.
        tbl.push_back(v("il_rst",   1, 0, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("il_req",   1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("il_rw",    1, 1, 2'b01, C_RW,   C_NONE, 8'h77, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("il_err",   1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b01, C_NONE, 8'h00));
        tbl.push_back(v("il_cmd",   1, 1, 2'b01, C_SRA,  C_NONE, 8'hA5, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("il_cmdm",  1, 1, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b01, 2'b00, 2'b00, C_SRA,  8'hA5));
        tbl.push_back(v("il_arst",  1, 0, 2'b01, C_NONE, C_NONE, 8'h00, 8'h00, 1, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));
        tbl.push_back(v("il_post",  2, 1, 2'b00, C_NONE, C_NONE, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 2'b00, C_NONE, 8'h00));

        foreach (tbl[i]) apply(tbl[i]);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Shares one `i2c_master_byte_ctrl` command port among `NUM_REQ` requesters, e.g. the Si5340 config loader and a status poller. It grants the bus round-robin and holds the grant for a whole I2C transaction, from START to STOP. Each accepted byte command is latched and replayed to the byte controller until `cmd_ack`. If a requester abandons the bus, stalls, or loses arbitration, the block recovers the bus with a forced STOP.

## Interface

Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `DATA_WIDTH`, default 8: byte width.
- `IDLE_TIMEOUT`, default 1_000_000: granted cycles with no command before the grant is revoked.

Ports:
- `clk_i`  in  1  clock.
- `arstn_i`  in  1  reset, asynchronous, active-low.
- `req_i`  in  NUM_REQ  bus request, one bit per requester, level.
- `start_i`, `stop_i`, `read_i`, `write_i`, `ack_in_i`  in  NUM_REQ each  per-requester byte command bits.
- `din_i`  in  NUM_REQ×DATA_WIDTH  per-requester write byte.
- `grant_o`  out  NUM_REQ  one-hot grant, registered.
- `cmd_ack_o`  out  NUM_REQ  command done, to the granted requester only.
- `err_o`  out  NUM_REQ  one-cycle abort pulse to the granted requester.
- `dout_o`  out  DATA_WIDTH  read byte, broadcast from `m_dout_i`.
- `ack_out_o`  out  1  slave ACK, broadcast from `m_ack_out_i`.
- `m_start_o`, `m_stop_o`, `m_read_o`, `m_write_o`, `m_ack_in_o`  out  1 each  to the byte controller.
- `m_din_o`  out  DATA_WIDTH  to the byte controller.
- `m_cmd_ack_i`, `m_ack_out_i`, `m_al_i`  in  1 each  from the byte controller.
- `m_dout_i`  in  DATA_WIDTH  from the byte controller.

## Operation

State machine states: IDLE, BUSY, CMD, FORCE_STOP, RELEASE.

- **IDLE**
  - If any `req_i` bit is set, the round-robin picker selects the next requester after `last_grant`.
  - `grant_o` is set in the following cycle and the FSM enters BUSY.
- **BUSY**
  - Any command bit from the granted requester latches `{start, stop, read, write, ack_in, din}` into `cmd_q` and the FSM enters CMD.
  - If `read` and `write` are both set, the command is dropped and `err_o` pulses; the FSM stays in BUSY.
  - If `req_i[g]` is low and no command is present:
    - go to FORCE_STOP if `in_txn` is set;
    - otherwise go to RELEASE.
  - The idle counter increments while no command is present. On reaching `IDLE_TIMEOUT`, `err_o` pulses, then the FSM goes to FORCE_STOP or RELEASE using the same `in_txn` rule.
- **CMD**
  - `m_*` is driven from `cmd_q`.
  - On `m_cmd_ack_i`:
    - `cmd_ack_o[g]` is driven combinationally in the same cycle;
    - `in_txn` is set if `cmd_q.start`;
    - `in_txn` is cleared if `cmd_q.stop`;
    - the FSM returns to BUSY with the idle counter cleared.
  - Command inputs are ignored in the first BUSY cycle after an ack (guard cycle).
- **FORCE_STOP**
  - `m_stop_o` and `m_ack_in_o` are held at 1 until `m_cmd_ack_i`, then `in_txn` is cleared and the FSM enters RELEASE.
  - `err_o[g]` pulses on entry if the cause was an abandoned transaction.
- **RELEASE**
  - Lasts one cycle. `grant_o` is cleared, `last_grant` is set to g, and the FSM returns to IDLE.
- **Arbitration lost:** `m_al_i` in any granted state:
  - clears `m_*`;
  - pulses `err_o[g]`;
  - clears `in_txn`;
  - sends the FSM to RELEASE. No STOP is issued, because the bus is owned by another master.
- **Output gating:** all `m_*` outputs and `m_din_o` are 0 outside CMD and FORCE_STOP.

## Timing

- **Reset values:**
  - `grant_o`, `cmd_ack_o`, `err_o` = 0.
  - All `m_*` = 0; `m_din_o` = 0.
  - `last_grant` = NUM_REQ-1, so requester 0 wins first.
  - Idle counter = 0; `in_txn` = 0.
- `dout_o` and `ack_out_o` are pass-through with no reset value.
- **Reset mid-CMD:** all outputs drop immediately. The byte controller is reset by the same `arstn_i`.
- **Grant latency:** `req_i` seen in IDLE at cycle t gives `grant_o` at cycle t+1.
- **Command latency:** a command seen at cycle k gives `m_*` at cycle k+1, held through the `m_cmd_ack_i` cycle.
- **Re-grant gap:** from RELEASE, the next grant appears no earlier than 2 cycles later.
- **Idle counter:** width `$clog2(IDLE_TIMEOUT+1)`. It saturates, never wraps.
- **Simultaneous events:**
  - `m_al_i` takes priority over `m_cmd_ack_i` in the same cycle.
  - A requester dropping `req_i` while in CMD has no effect until the ack, after which the BUSY rules apply.

## Structure

- Add to `cfg_pkg`:
  - `arb_state_t` enum;
  - `i2c_cmd_t` packed struct `{start, stop, read, write, ack_in, din}`;
  - `IDLE_TIMEOUT` default.
- Sub-module `rr_picker`: combinational round-robin, taking `req`, `last` and returning a one-hot `pick`.

## Test plan

- **Single write:** `req_i`=01, then start+write with `din`=0xEA.
  - `m_start_o`, `m_write_o` and `m_din_o`=0xEA appear one cycle later.
  - `m_cmd_ack_i` at +20 gives `cmd_ack_o`=01 in the same cycle; `m_*` is 0 on the next cycle.
- **Contention:** `req_i`=11 out of reset.
  - `grant_o`=01 first. After RELEASE, `grant_o`=10 two cycles later.
  - Re-raising `req_i[0]` waits for requester 1's release.
- **Abandon:** requester 0 sends start+write, is acked, then drops `req_i`.
  - FORCE_STOP asserts `m_stop_o` until ack.
  - `err_o`=01 pulses, then `grant_o`=00.
- **Timeout:** `IDLE_TIMEOUT`=16, grant held with no command.
  - `err_o` pulses at cycle 16, then RELEASE, or a forced STOP if `in_txn` is set.
- **Arbitration lost:** assert `m_al_i` during CMD together with `m_cmd_ack_i`.
  - `m_*` drops the next cycle and `err_o` pulses.
  - `cmd_ack_o` stays 0; the other requester is granted 2 cycles later.
- **Illegal command:** read+write together, then `arstn_i` low mid-CMD.
  - The illegal command gives an `err_o` pulse with no `m_*` activity.
  - The reset returns all outputs to their reset values asynchronously.
